// File: rtl/multiport_fifo_pkg.sv
// Shared helpers for the multi-port FIFO family: width derivation,
// modulo-DEPTH pointer addition and population count.
package multiport_fifo_pkg;

   // Bits needed for a pointer in 0..depth-1 (never less than one bit).
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Bits needed for a counter in 0..depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Circular add; ptr + n never exceeds 2*depth-1, so one subtraction suffices.
   function automatic int wrap_add(input int ptr, input int n, input int depth);
      int s;
      s = ptr + n;
      if (s >= depth) s = s - depth;
      return s;
   endfunction

   // Number of set bits in a request vector of up to 32 ports.
   function automatic int popcount(input logic [31:0] v);
      int c;
      c = 0;
      for (int i = 0; i < 32; i++) c = c + int'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/multiport_fifo_compact.sv
// Prefix-sum rank generator: each active push port gets an offset equal to
// the number of active ports below it, so the group lands contiguously.
module multiport_fifo_compact
   import multiport_fifo_pkg::*;
#(
   parameter int NUM_WR = 2
) (
   input  logic [NUM_WR-1:0]                           push_i,
   output logic [NUM_WR-1:0][$clog2(NUM_WR+1)-1:0]     rank_o,
   output logic [$clog2(NUM_WR+1)-1:0]                 np_o
);

   localparam int OFF_W = $clog2(NUM_WR + 1);

   logic [OFF_W-1:0] acc;

   // Running count of lower-index active ports gives each port its rank.
   always_comb begin
      rank_o = '0;
      acc    = '0;
      for (int i = 0; i < NUM_WR; i++) begin
         rank_o[i] = acc;
         acc       = acc + OFF_W'(push_i[i]);
      end
      np_o = OFF_W'(popcount(32'(push_i)));
   end

endmodule

// File: rtl/multiport_fifo.sv
// N-write / M-read circular FIFO with first-word-fall-through read lanes,
// all-or-nothing push groups, clamped pops and synchronous flush.
// Optional sticky error flag enabled by defining MULTIPORT_FIFO_ERR_EN.
module multiport_fifo
   import multiport_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int NUM_WR     = 2,
   parameter int NUM_RD     = 2,
   parameter int AF_THRESH  = NUM_WR
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 flush_i,
   input  logic [NUM_WR-1:0]                    push_i,
   input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    data_i,
   output logic                                 push_ok_o,
   output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    data_o,
   output logic [NUM_RD-1:0]                    valid_o,
   input  logic [$clog2(NUM_RD+1)-1:0]          pop_cnt_i,
   output logic [$clog2(DEPTH+1)-1:0]           count_o,
   output logic                                 full_o,
   output logic                                 empty_o,
   output logic                                 almost_full_o,
   output logic                                 err_o
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = cnt_width(DEPTH);
   localparam int OFF_W = cnt_width(NUM_WR);
   localparam int POP_W = cnt_width(NUM_RD);

   logic [DATA_WIDTH-1:0]              mem_q [DEPTH];
   logic [PTR_W-1:0]                   rd_ptr_q, wr_ptr_q, rd_ptr_n, wr_ptr_n;
   logic [CNT_W-1:0]                   count_q, count_n, pop_eff;
   logic [NUM_WR-1:0][OFF_W-1:0]       rank;
   logic [OFF_W-1:0]                   np;
   logic [NUM_WR-1:0][PTR_W-1:0]       wr_idx;
   logic [NUM_RD-1:0][PTR_W-1:0]       rd_idx;
   logic                               push_ok;
   int                                 free_slots;

   // Pop requests beyond the current occupancy are clamped, not honoured.
   function automatic logic [CNT_W-1:0] sat_pop(input logic [POP_W-1:0] req,
                                                input logic [CNT_W-1:0] cnt);
      if (int'(req) > int'(cnt)) return cnt;
      return CNT_W'(req);
   endfunction

   multiport_fifo_compact #(
      .NUM_WR (NUM_WR)
   ) u_compact (
      .push_i (push_i),
      .rank_o (rank),
      .np_o   (np)
   );

   // Acceptance looks only at registered occupancy: a same-cycle pop gives no credit.
   assign free_slots = DEPTH - int'(count_q);
   assign push_ok    = (np != '0) && (free_slots >= int'(np));
   assign push_ok_o  = push_ok;
   assign pop_eff    = sat_pop(pop_cnt_i, count_q);

   // Next-state pointers/count and per-port / per-lane wrapped slot indices.
   always_comb begin
      wr_ptr_n = PTR_W'(wrap_add(int'(wr_ptr_q), int'(np), DEPTH));
      rd_ptr_n = PTR_W'(wrap_add(int'(rd_ptr_q), int'(pop_eff), DEPTH));
      count_n  = CNT_W'(int'(count_q) + (push_ok ? int'(np) : 0) - int'(pop_eff));
      for (int i = 0; i < NUM_WR; i++)
         wr_idx[i] = PTR_W'(wrap_add(int'(wr_ptr_q), int'(rank[i]), DEPTH));
      for (int k = 0; k < NUM_RD; k++)
         rd_idx[k] = PTR_W'(wrap_add(int'(rd_ptr_q), k, DEPTH));
   end

   // Storage write: only whole accepted groups land, compacted by rank.
   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) begin
         for (int i = 0; i < NUM_WR; i++)
            if (push_i[i]) mem_q[wr_idx[i]] <= data_i[i];
      end
   end

   // Pointer and occupancy state; flush outranks any push or pop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_n;
         rd_ptr_q <= rd_ptr_n;
         count_q  <= count_n;
      end
   end

   // Read lanes present the oldest entries straight from storage.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         data_o[k]  = mem_q[rd_idx[k]];
         valid_o[k] = (k < int'(count_q));
      end
   end

   assign count_o       = count_q;
   assign full_o        = (int'(count_q) == DEPTH);
   assign empty_o       = (count_q == '0);
   assign almost_full_o = (free_slots < AF_THRESH);

`ifdef MULTIPORT_FIFO_ERR_EN
   logic err_q;
   logic err_event;

   assign err_event = ((np != '0) && !push_ok) || (int'(pop_cnt_i) > int'(count_q));

   // Sticky error: rejected push group or over-pop; flush clears it first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        err_q <= 1'b0;
      else if (flush_i)   err_q <= 1'b0;
      else if (err_event) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_multiport_fifo.sv
// Directed bench for multiport_fifo (DEPTH 8, two push ports, two read lanes).
module tb_multiport_fifo;

`ifdef MULTIPORT_FIFO_ERR_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              flush_i;
   logic [1:0]        push_i;
   logic [1:0][31:0]  data_i;
   logic              push_ok_o;
   logic [1:0][31:0]  data_o;
   logic [1:0]        valid_o;
   logic [1:0]        pop_cnt_i;
   logic [3:0]        count_o;
   logic              full_o, empty_o, almost_full_o, err_o;

   int n_cmp  = 0;
   int n_fail = 0;

   multiport_fifo #(
      .DATA_WIDTH (32),
      .DEPTH      (8),
      .NUM_WR     (2),
      .NUM_RD     (2),
      .AF_THRESH  (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .flush_i       (flush_i),
      .push_i        (push_i),
      .data_i        (data_i),
      .push_ok_o     (push_ok_o),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .pop_cnt_i     (pop_cnt_i),
      .count_o       (count_o),
      .full_o        (full_o),
      .empty_o       (empty_o),
      .almost_full_o (almost_full_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] p, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] pc, input logic fl);
      push_i    = p;
      data_i[0] = d0;
      data_i[1] = d1;
      pop_cnt_i = pc;
      flush_i   = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      push_i    = '0;
      pop_cnt_i = '0;
      flush_i   = 1'b0;
   endtask

   initial begin
      rst_ni    = 1'b0;
      flush_i   = 1'b0;
      push_i    = '0;
      data_i    = '0;
      pop_cnt_i = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_count", 32'(count_o), 0);
      chk("rst_empty", 32'(empty_o), 1);
      chk("rst_full", 32'(full_o), 0);
      chk("rst_af", 32'(almost_full_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_err", 32'(err_o), 0);
      rst_ni = 1'b1;

      // Two-port push into empty FIFO
      drive(2'b11, 32'hA0, 32'hB0, 2'd0, 1'b0);
      chk("push2_ok", 32'(push_ok_o), 1);
      tick();
      chk("push2_count", 32'(count_o), 2);
      chk("push2_valid", 32'(valid_o), 3);
      chk("push2_d0", data_o[0], 32'hA0);
      chk("push2_d1", data_o[1], 32'hB0);
      chk("push2_empty", 32'(empty_o), 0);

      // Fill up to 7 entries; almost_full turns on at free=1
      drive(2'b11, 32'h11, 32'h12, 2'd0, 1'b0); tick();
      drive(2'b11, 32'h13, 32'h14, 2'd0, 1'b0); tick();
      chk("c6_count", 32'(count_o), 6);
      chk("c6_af", 32'(almost_full_o), 0);
      drive(2'b01, 32'h15, 32'h0, 2'd0, 1'b0); tick();
      chk("c7_count", 32'(count_o), 7);
      chk("c7_af", 32'(almost_full_o), 1);
      chk("c7_full", 32'(full_o), 0);

      // Two-entry group does not fit in one free slot
      drive(2'b11, 32'h77, 32'h78, 2'd0, 1'b0);
      chk("rej_ok", 32'(push_ok_o), 0);
      tick();
      chk("rej_count", 32'(count_o), 7);
      chk("rej_err", 32'(err_o), 32'(ERR_ON));

      // Single push fills the last slot
      drive(2'b01, 32'h16, 32'h0, 2'd0, 1'b0);
      chk("last_ok", 32'(push_ok_o), 1);
      tick();
      chk("full_count", 32'(count_o), 8);
      chk("full_flag", 32'(full_o), 1);

      // Push and pop while full: pop honoured, push rejected
      drive(2'b01, 32'h99, 32'h0, 2'd1, 1'b0);
      chk("fullpp_ok", 32'(push_ok_o), 0);
      tick();
      chk("fullpp_count", 32'(count_o), 7);
      chk("fullpp_full", 32'(full_o), 0);
      chk("fullpp_d0", data_o[0], 32'hB0);

      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("c5_count", 32'(count_o), 5);
      chk("c5_d0", data_o[0], 32'h12);
      chk("c5_d1", data_o[1], 32'h13);

      // Flush with a concurrent push: everything discarded, err cleared
      drive(2'b11, 32'h55, 32'h56, 2'd0, 1'b1);
      chk("flush_ok", 32'(push_ok_o), 1);
      tick();
      chk("flush_count", 32'(count_o), 0);
      chk("flush_valid", 32'(valid_o), 0);
      chk("flush_err", 32'(err_o), 0);
      chk("flush_empty", 32'(empty_o), 1);

      // Refill to 7 from pointer 0 so rd/wr end up at 7
      drive(2'b11, 32'h21, 32'h22, 2'd0, 1'b0); tick();
      drive(2'b11, 32'h23, 32'h24, 2'd0, 1'b0); tick();
      drive(2'b11, 32'h25, 32'h26, 2'd0, 1'b0); tick();
      chk("r6_af", 32'(almost_full_o), 0);
      drive(2'b01, 32'h27, 32'h0, 2'd0, 1'b0); tick();
      chk("r7_count", 32'(count_o), 7);
      chk("r7_af", 32'(almost_full_o), 1);
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("r5_d0", data_o[0], 32'h23);
      chk("r5_af", 32'(almost_full_o), 0);
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("r1_count", 32'(count_o), 1);
      chk("r1_valid", 32'(valid_o), 1);
      chk("r1_d0", data_o[0], 32'h27);

      // Over-pop: clamped to occupancy
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("opop_count", 32'(count_o), 0);
      chk("opop_empty", 32'(empty_o), 1);
      chk("opop_err", 32'(err_o), 32'(ERR_ON));

      // Wrap: C at slot 7, D at slot 0
      drive(2'b11, 32'hC0, 32'hD0, 2'd0, 1'b0); tick();
      chk("wrap_count", 32'(count_o), 2);
      chk("wrap_d0", data_o[0], 32'hC0);
      chk("wrap_d1", data_o[1], 32'hD0);
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("wrap_empty", 32'(empty_o), 1);
      drive(2'b11, 32'h31, 32'h32, 2'd0, 1'b0); tick();
      chk("rdptr1_d0", data_o[0], 32'h31);
      chk("rdptr1_d1", data_o[1], 32'h32);
      drive(2'b01, 32'h33, 32'h0, 2'd0, 1'b0); tick();
      chk("c3_count", 32'(count_o), 3);

      // Upper port only, with a simultaneous single pop
      drive(2'b10, 32'h0, 32'hE0, 2'd1, 1'b0);
      chk("p10_ok", 32'(push_ok_o), 1);
      tick();
      chk("p10_count", 32'(count_o), 3);
      chk("p10_d0", data_o[0], 32'h32);
      chk("p10_d1", data_o[1], 32'h33);
      drive(2'b00, 32'h0, 32'h0, 2'd2, 1'b0); tick();
      chk("p10_e_count", 32'(count_o), 1);
      chk("p10_e_d0", data_o[0], 32'hE0);

      // Asynchronous reset mid-cycle clears state at once
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_count", 32'(count_o), 0);
      chk("arst_valid", 32'(valid_o), 0);
      chk("arst_err", 32'(err_o), 0);
      chk("arst_empty", 32'(empty_o), 1);
      rst_ni = 1'b1;
      tick();
      chk("post_rst_empty", 32'(empty_o), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multiport_fifo.md
Name: multiport_fifo

Overview:
Parametrised N-write/M-read circular FIFO for the MMU request and refill paths.
- Accepts up to NUM_WR entries per cycle, compacted in port order.
- Presents the oldest NUM_RD entries in first-word-fall-through form.
- Retires 0..NUM_RD entries per cycle.
- Provides occupancy, almost-full back-pressure and a synchronous flush.

Parameters:
- DATA_WIDTH, 32, entry width in bits.
- DEPTH, 8, number of entries; any value >= max(NUM_WR, NUM_RD) and >= 2, not necessarily a power of two.
- NUM_WR, 2, number of push ports; port 0 is oldest in program order.
- NUM_RD, 2, number of read lanes.
- AF_THRESH, NUM_WR, almost_full_o asserts when free slots < AF_THRESH.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all entries.
- push_i  in  NUM_WR  per-port push request.
- data_i  in  NUM_WR x DATA_WIDTH  per-port push data.
- push_ok_o  out  1  combinational; the whole push group is accepted this cycle.
- data_o  out  NUM_RD x DATA_WIDTH  lane k = k-th oldest entry.
- valid_o  out  NUM_RD  lane k valid iff k < count.
- pop_cnt_i  in  $clog2(NUM_RD+1)  number of entries retired this cycle.
- count_o  out  $clog2(DEPTH+1)  registered occupancy.
- full_o / empty_o / almost_full_o  out  1 each  status flags, decoded from count_q.
- err_o  out  1  sticky error flag; see Optional Feature.

Behaviour:
- State:
  - rd_ptr_q and wr_ptr_q, each in range 0..DEPTH-1.
  - count_q in range 0..DEPTH.
  - Storage array, not reset.
- Ptr arithmetic: next = ptr + n; if next >= DEPTH, subtract DEPTH. Use a width wide enough to hold DEPTH-1+NUM_WR with no overflow.
- Push:
  - np = popcount(push_i).
  - push_ok_o = (np != 0) && (DEPTH - count_q >= np).
  - Acceptance is all-or-nothing; partial groups are never written.
  - The same-cycle pop gives no credit, so the check depends only on count_q.
- Compaction: active ports are written to wr_ptr_q + rank, where rank = number of active ports with a lower index. Example: push_i = 2'b10 writes data_i[1] at wr_ptr_q.
- Pop:
  - Effective pop np_eff = min(pop_cnt_i, count_q). Excess is ignored.
  - rd_ptr advances by np_eff.
- Count: count_n = count_q + (push_ok_o ? np : 0) - np_eff.
- Simultaneous push and pop on the same slot: when full, the pop is honoured, but the push is still rejected because there is no credit.
- Read lanes:
  - data_o[k] = mem[rd_ptr_q + k] (wrapped). Combinational from registers.
  - data_o of lanes with valid_o=0 is don't-care.
  - Latency: a pushed entry becomes visible on data_o/valid_o the cycle after the push.
- Flush:
  - Highest priority after reset.
  - Pointers and count go to 0.
  - Any push or pop in the same cycle is discarded.
  - push_ok_o still reflects the combinational check; consumers must ignore it under flush.
- Reset values:
  - count_o = 0, empty_o = 1, full_o = 0.
  - almost_full_o = (DEPTH < AF_THRESH).
  - valid_o = 0, err_o = 0.
- Reset asserted mid-operation clears state immediately (asynchronous); the first cycle after deassertion behaves as empty.

Optional Feature:
- Macro: MULTIPORT_FIFO_ERR_EN.
- With the macro:
  - err_o is a registered sticky flag.
  - Set the cycle after either (np != 0 && !push_ok_o), i.e. a rejected push group, or pop_cnt_i > count_q.
  - Cleared by reset or flush_i.
  - A flush in the same cycle as an error event clears it (flush wins).
- Without the macro: err_o is tied to 0 and no register is generated.

Decomposition:
- Package multiport_fifo_pkg:
  - ptr_t / cnt_t width helper functions.
  - wrap_add function.
  - popcount function.
- Sub-module multiport_fifo_compact: combinational prefix-sum rank generator. It maps push_i to per-port write offsets and the total np, and is reused by future issue queues.

Test Plan:
- Reset, then push_i=2'b11, data_i = {A, B} -> next cycle count_o=2, valid_o=2'b11, data_o[0]=A, data_o[1]=B.
- count=7 of 8 with push_i=2'b11 -> push_ok_o=0, count stays 7. With MULTIPORT_FIFO_ERR_EN, err_o=1 next cycle. push_i=2'b01 -> accepted, full_o=1.
- Wrap: rd_ptr=wr_ptr=7 with count=0; push {C, D}, then pop_cnt_i=2 -> C at slot 7, D at slot 0; data_o = C, D; then empty_o=1 and rd_ptr=1.
- push_i=2'b10 with data_i[1]=E, simultaneously pop_cnt_i=1 at count=3 -> E written at wr_ptr; count stays 3; lanes shift by one.
- pop_cnt_i=2 at count=1 -> count 0, empty_o=1; err_o=1 only when the macro is defined.
- count=5, flush_i=1 together with push_i=2'b11 -> next cycle count_o=0, valid_o=0, err_o=0. Then almost_full_o toggles at count=7 (free=1 < 2).
